// File: rtl/fft_out_frame_buffer.sv
// Captures one FFT output frame (optionally bit-reversed on write) and replays it in natural bin
// order over a valid/ready stream together with the registered per-bin power |X|^2.
module fft_out_frame_buffer #(
   parameter int N_PTS     = 64,
   parameter int LOG2N     = 6,
   parameter int DW        = 16,
   parameter int BITREV_IN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Data_Out,
   input  logic [2*DW-1:0]   Out_Stream,
   input  logic              rd_ready,
   input  logic              clr_ovf,
   output logic              rd_valid,
   output logic [2*DW-1:0]   rd_data,
   output logic [2*DW:0]     rd_mag,
   output logic [LOG2N-1:0]  rd_bin,
   output logic              rd_last,
   output logic              frame_busy,
   output logic              overrun
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] READOUT = 2'd2;

   localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(N_PTS - 1);

   logic [1:0]        state_reg;
   logic [LOG2N-1:0]  wr_cnt_reg;
   logic [LOG2N-1:0]  rd_cnt_reg;
   logic [LOG2N-1:0]  wr_cnt_rev;
   logic [LOG2N-1:0]  wr_addr;
   logic [2*DW-1:0]   mem [N_PTS];
   logic [2*DW-1:0]   rd_word;
   logic signed [DW-1:0]   rd_re;
   logic signed [DW-1:0]   rd_im;
   logic signed [2*DW-1:0] re_sq;
   logic signed [2*DW-1:0] im_sq;
   logic [2*DW:0]     mag_next;
   logic              wr_en;
   logic              transfer;
   logic              load;

   genvar gi;
   generate
      for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
         assign wr_cnt_rev[gi] = wr_cnt_reg[LOG2N-1-gi];
      end
   endgenerate

   assign wr_addr = (BITREV_IN != 0) ? wr_cnt_rev : wr_cnt_reg;
   assign wr_en   = Data_Out && (state_reg != READOUT);

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem[wr_addr] <= Out_Stream;
      end
   end

   // Each square is non-negative and at most 2^30, so zero-extending both into the
   // extra bit lets the 2^31 corner case (both components -32768) land without wrap.
   assign rd_word  = mem[rd_cnt_reg];
   assign rd_re    = rd_word[2*DW-1:DW];
   assign rd_im    = rd_word[DW-1:0];
   assign re_sq    = rd_re * rd_re;
   assign im_sq    = rd_im * rd_im;
   assign mag_next = {1'b0, re_sq} + {1'b0, im_sq};

   assign transfer = rd_valid && rd_ready;
   assign load     = (state_reg == READOUT) && (!rd_valid || (transfer && !rd_last));

   assign frame_busy = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         wr_cnt_reg <= '0;
         rd_cnt_reg <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         rd_mag     <= '0;
         rd_bin     <= '0;
         rd_last    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (Data_Out) begin
                  wr_cnt_reg <= LOG2N'(1);
                  state_reg  <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (Data_Out) begin
                  if (wr_cnt_reg == LAST_BIN) begin
                     wr_cnt_reg <= '0;
                     state_reg  <= READOUT;
                  end else begin
                     wr_cnt_reg <= wr_cnt_reg + 1'b1;
                  end
               end
            end
            READOUT: begin
               if (transfer && rd_last) begin
                  rd_valid   <= 1'b0;
                  rd_last    <= 1'b0;
                  rd_cnt_reg <= '0;
                  state_reg  <= IDLE;
               end else if (load) begin
                  rd_valid   <= 1'b1;
                  rd_data    <= rd_word;
                  rd_mag     <= mag_next;
                  rd_bin     <= rd_cnt_reg;
                  rd_last    <= (rd_cnt_reg == LAST_BIN);
                  rd_cnt_reg <= rd_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase

         // A strobe arriving while the frame drains is lost; set beats a same-cycle clear.
         if (Data_Out && (state_reg == READOUT)) begin
            overrun <= 1'b1;
         end else if (clr_ovf) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_out_frame_buffer.sv
// Directed bench for fft_out_frame_buffer: natural and bit-reversed capture, stalls,
// magnitude corner case, overrun handling and mid-frame reset.
module tb_fft_out_frame_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        strobe = 1'b0;
   logic        sel = 1'b0;
   logic        rd_ready = 1'b0;
   logic        clr_ovf = 1'b0;
   logic [31:0] Out_Stream = '0;

   logic        data_out0, data_out1;
   logic        rd_valid0, rd_valid1, rd_last0, rd_last1;
   logic        busy0, busy1, ovf0, ovf1;
   logic [31:0] rd_data0, rd_data1;
   logic [32:0] rd_mag0, rd_mag1;
   logic [5:0]  rd_bin0, rd_bin1;

   logic        o_valid, o_last, o_busy, o_ovf;
   logic [31:0] o_data;
   logic [32:0] o_mag;
   logic [5:0]  o_bin;

   int n_cmp = 0;
   int n_err = 0;

   assign data_out0 = strobe & ~sel;
   assign data_out1 = strobe & sel;

   assign o_valid = sel ? rd_valid1 : rd_valid0;
   assign o_last  = sel ? rd_last1  : rd_last0;
   assign o_busy  = sel ? busy1     : busy0;
   assign o_ovf   = sel ? ovf1      : ovf0;
   assign o_data  = sel ? rd_data1  : rd_data0;
   assign o_mag   = sel ? rd_mag1   : rd_mag0;
   assign o_bin   = sel ? rd_bin1   : rd_bin0;

   fft_out_frame_buffer #(.N_PTS(64), .LOG2N(6), .DW(16), .BITREV_IN(0)) dut0 (
      .clk(clk), .rst(rst), .Data_Out(data_out0), .Out_Stream(Out_Stream),
      .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(rd_valid0), .rd_data(rd_data0),
      .rd_mag(rd_mag0), .rd_bin(rd_bin0), .rd_last(rd_last0), .frame_busy(busy0),
      .overrun(ovf0)
   );

   fft_out_frame_buffer #(.N_PTS(64), .LOG2N(6), .DW(16), .BITREV_IN(1)) dut1 (
      .clk(clk), .rst(rst), .Data_Out(data_out1), .Out_Stream(Out_Stream),
      .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(rd_valid1), .rd_data(rd_data1),
      .rd_mag(rd_mag1), .rd_bin(rd_bin1), .rd_last(rd_last1), .frame_busy(busy1),
      .overrun(ovf1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] brev(input logic [5:0] v);
      logic [5:0] r;
      for (int i = 0; i < 6; i++) r[i] = v[5-i];
      return r;
   endfunction

   // Mode 0: {k,-k}; 1: bit-reversed capture; 2: mode 0 with bin 5 = {-32768,-32768}; 3: {k+100,k}
   function automatic logic [31:0] exp_data(input int mode, input int k);
      logic [15:0] kk;
      logic [15:0] nk;
      logic [5:0]  k6;
      kk = k[15:0];
      nk = 16'd0 - kk;
      k6 = k[5:0];
      case (mode)
         1:       return {kk, 10'd0, brev(k6)};
         2:       return (k == 5) ? 32'h8000_8000 : {kk, nk};
         3:       return {kk + 16'd100, kk};
         default: return {kk, nk};
      endcase
   endfunction

   function automatic logic [31:0] in_data(input int mode, input int j);
      logic [5:0] j6;
      j6 = j[5:0];
      if (mode == 1) return {10'd0, brev(j6), j[15:0]};
      return exp_data(mode, j);
   endfunction

   function automatic logic [32:0] exp_mag(input logic [31:0] d);
      logic signed [15:0] re, im;
      logic signed [32:0] r2, i2;
      re = d[31:16];
      im = d[15:0];
      r2 = re * re;
      i2 = im * im;
      return 33'(r2 + i2);
   endfunction

   task automatic send_frame(input int mode, input int n, input bit gap);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         strobe = 1'b1;
         Out_Stream = in_data(mode, j);
         if (gap) begin
            @(negedge clk);
            strobe = 1'b0;
         end
      end
      @(negedge clk);
      strobe = 1'b0;
   endtask

   task automatic drain(input int mode, input bit toggle);
      int k = 0;
      int cyc = 0;
      bit hold = 1'b0;
      logic [31:0] held_data;
      logic [5:0]  held_bin;
      rd_ready = 1'b1;
      while (k < 64 && cyc < 2000) begin
         if (hold) begin
            check("hold_data", o_data, held_data);
            check("hold_bin", o_bin, held_bin);
            hold = 1'b0;
         end
         if (o_valid && rd_ready) begin
            check("bin", o_bin, k[5:0]);
            check("data", o_data, exp_data(mode, k));
            check("mag", o_mag, exp_mag(exp_data(mode, k)));
            check("last", o_last, (k == 63));
            if (mode == 2 && k == 5) check("mag_min", o_mag, 64'h0_8000_0000);
            k++;
         end else if (o_valid) begin
            held_data = o_data;
            held_bin  = o_bin;
            hold = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (toggle) rd_ready = ~rd_ready;
      end
      check("beats", k, 64);
      check("valid_after", o_valid, 1'b0);
      check("busy_after", o_busy, 1'b0);
      rd_ready = 1'b0;
      $display("frame mode %0d toggle %0d: %0d beats in %0d cycles", mode, toggle, k, cyc);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_valid", rd_valid0, 1'b0);
      check("rst_data", rd_data0, 32'd0);
      check("rst_mag", rd_mag0, 33'd0);
      check("rst_bin", rd_bin0, 6'd0);
      check("rst_last", rd_last0, 1'b0);
      check("rst_busy", busy0, 1'b0);
      check("rst_ovf", ovf0, 1'b0);
      check("rst_valid1", rd_valid1, 1'b0);

      // Natural order, full-rate capture and drain
      send_frame(0, 64, 1'b0);
      check("busy_readout", o_busy, 1'b1);
      drain(0, 1'b0);

      // Bit-reversed capture on the second instance
      sel = 1'b1;
      send_frame(1, 64, 1'b0);
      drain(1, 1'b0);
      sel = 1'b0;

      // Strobes every other cycle, consumer stalling on alternate cycles
      send_frame(0, 64, 1'b1);
      drain(0, 1'b1);

      // Most negative components in bin 5
      send_frame(2, 64, 1'b0);
      drain(2, 1'b0);

      // Extra strobes while the frame waits to drain
      send_frame(0, 64, 1'b0);
      check("ovf_before", o_ovf, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         strobe = 1'b1;
         Out_Stream = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      strobe = 1'b0;
      check("ovf_set", o_ovf, 1'b1);
      check("ovf_bin0", o_bin, 6'd0);
      drain(0, 1'b0);
      check("ovf_sticky", o_ovf, 1'b1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      check("ovf_clear", o_ovf, 1'b0);

      // Reset during capture discards the partial frame
      send_frame(3, 20, 1'b0);
      check("busy_capture", o_busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", o_valid, 1'b0);
      check("mid_rst_busy", o_busy, 1'b0);
      send_frame(3, 64, 1'b0);
      drain(3, 1'b0);
      check("final_ovf", o_ovf, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
